// File: rtl/axi4lite_cmd_sequencer_if.sv
// Command bus between the sequencer and the downstream AXI4-Lite master.
// The "master" modport is the side that issues commands; "slave" executes them.
interface axi4lite_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  start_write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start_read;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  done;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output start_write, write_addr, wr_data, start_read, read_addr,
        input  done, read_data
    );

    modport slave (
        input  start_write, write_addr, wr_data, start_read, read_addr,
        output done, read_data
    );
endinterface

// File: rtl/axi4lite_cmd_sequencer.sv
// Command front-end for axi4lite_master: synchronises and edge-detects pin
// requests, queues them in a small FIFO and issues them one at a time,
// waiting for done (or a timeout) before issuing the next.
module axi4lite_cmd_sequencer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        req_wr,
    input  logic                        req_rd,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic                        clr_err,
    axi4lite_cmd_sequencer_if.master    bus,
    output logic                        rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        drop_err,
    output logic                        timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    // Abort on the last permitted WAIT cycle so WAIT lasts at most TIMEOUT cycles.
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic                  is_read;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    logic [2:0]    wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
    logic          wr_edge_q, wr_edge_d, rd_edge_q, rd_edge_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    entry_t        cur_q, cur_d;
    logic [7:0]    timer_q, timer_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic          drop_err_q, drop_err_d, timeout_err_q, timeout_err_d;
    logic          push_req, push, pop, drop_evt, timeout_evt;
    entry_t        new_entry;

    // Synchroniser shift and registered rise detect (push lands 3 edges after the pin rises)
    always_comb begin
        wr_sync_d = {wr_sync_q[1:0], req_wr};
        rd_sync_d = {rd_sync_q[1:0], req_rd};
        wr_edge_d = wr_sync_q[1] & ~wr_sync_q[2];
        rd_edge_d = rd_sync_q[1] & ~rd_sync_q[2];
    end

    // FIFO push/pop bookkeeping; a write wins a same-cycle collision with a read
    always_comb begin
        push_req  = ena & (wr_edge_q | rd_edge_q);
        push      = push_req & ((count_q != FULL_LVL) | pop);
        drop_evt  = (ena & wr_edge_q & rd_edge_q) | (push_req & ~push);
        new_entry = '{is_read: ~wr_edge_q, addr: req_addr, wdata: req_wdata};
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Issue FSM: pop in IDLE, pulse start in ISSUE, wait for done or timeout
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cur_d       = cur_q;
        timer_d     = timer_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && ena) begin
                    pop     = 1'b1;
                    cur_d   = mem_q[rd_ptr_q];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (bus.done) begin
                    if (cur_q.is_read) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.read_data;
                    end
                    state_d = ST_IDLE;
                end else if (timer_q == TO_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky error flags; a new error event overrides a same-cycle clear
    always_comb begin
        drop_err_d    = clr_err ? 1'b0 : drop_err_q;
        timeout_err_d = clr_err ? 1'b0 : timeout_err_q;
        if (drop_evt)    drop_err_d    = 1'b1;
        if (timeout_evt) timeout_err_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q     <= '0;
            rd_sync_q     <= '0;
            wr_edge_q     <= 1'b0;
            rd_edge_q     <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            drop_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_sync_q     <= wr_sync_d;
            rd_sync_q     <= rd_sync_d;
            wr_edge_q     <= wr_edge_d;
            rd_edge_q     <= rd_edge_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cur_q         <= cur_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            drop_err_q    <= drop_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.start_write = (state_q == ST_ISSUE) & ~cur_q.is_read;
    assign bus.start_read  = (state_q == ST_ISSUE) &  cur_q.is_read;
    assign bus.write_addr  = cur_q.addr;
    assign bus.read_addr   = cur_q.addr;
    assign bus.wr_data     = cur_q.wdata;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = (state_q != ST_IDLE) | (count_q != '0);
    assign level           = count_q;
    assign drop_err        = drop_err_q;
    assign timeout_err     = timeout_err_q;
endmodule

// File: tb/tb_axi4lite_cmd_sequencer.sv
// Directed bench for axi4lite_cmd_sequencer; the bench plays the downstream master.
module tb_axi4lite_cmd_sequencer;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       req_wr = 1'b0;
    logic       req_rd = 1'b0;
    logic [1:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       clr_err = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [2:0] level;
    logic       drop_err;
    logic       timeout_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    axi4lite_cmd_sequencer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    axi4lite_cmd_sequencer #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(8),
        .DEPTH(4),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .req_wr(req_wr),
        .req_rd(req_rd),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .clr_err(clr_err),
        .bus(bus),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .level(level),
        .drop_err(drop_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Raise the request pins for two cycles, then drop them; address/data are left in place
    task automatic pulse_req(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] d);
        req_addr  = a;
        req_wdata = d;
        req_wr    = wr;
        req_rd    = rd;
        repeat (2) @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b0;
    endtask

    // Wait (bounded) for a start pulse and check its kind and payload
    task automatic wait_start(input string tag, input logic exp_rd, input logic [1:0] a, input logic [7:0] d);
        int unsigned n = 0;
        while (!(bus.start_write || bus.start_read) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            check({tag, "_start_seen"}, 0, 1);
        end else begin
            check({tag, "_start_read"}, bus.start_read, exp_rd);
            check({tag, "_start_write"}, bus.start_write, !exp_rd);
            if (exp_rd) begin
                check({tag, "_read_addr"}, bus.read_addr, a);
            end else begin
                check({tag, "_write_addr"}, bus.write_addr, a);
                check({tag, "_wr_data"}, bus.wr_data, d);
            end
        end
    endtask

    // One-cycle done pulse while the DUT sits in WAIT
    task automatic give_done(input logic [7:0] rd);
        @(negedge clk);
        bus.done      = 1'b1;
        bus.read_data = rd;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned starts;
        int unsigned k_to;
        int unsigned rsp_seen;
        bus.done      = 1'b0;
        bus.read_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_start", {bus.start_write, bus.start_read}, 0);
        check("rst_errs", {drop_err, timeout_err}, 0);
        check("rst_rsp", {rsp_valid, rsp_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. single write
        pulse_req(1'b1, 1'b0, 2'd2, 8'hA5);
        wait_start("wr1", 1'b0, 2'd2, 8'hA5);
        give_done(8'h00);
        check("wr1_rsp_valid", rsp_valid, 0);
        check("wr1_busy", busy, 0);

        // 2. read back
        pulse_req(1'b0, 1'b1, 2'd2, 8'h00);
        wait_start("rd1", 1'b1, 2'd2, 8'h00);
        give_done(8'hA5);
        check("rd1_rsp_valid", rsp_valid, 1);
        check("rd1_rsp_data", rsp_data, 8'hA5);
        @(negedge clk);
        check("rd1_rsp_pulse", rsp_valid, 0);
        check("rd1_rsp_hold", rsp_data, 8'hA5);

        // Edge while disabled is ignored
        ena = 1'b0;
        pulse_req(1'b1, 1'b0, 2'd1, 8'h11);
        repeat (6) @(negedge clk);
        check("ena0_level", level, 0);
        check("ena0_busy", busy, 0);
        check("ena0_drop", drop_err, 0);
        ena = 1'b1;
        repeat (2) @(negedge clk);

        // 3. burst of 5 writes with done held off, then a 6th
        for (int i = 0; i < 5; i++) begin
            pulse_req(1'b1, 1'b0, 2'(i), 8'(8'h10 + i));
            repeat (3) @(negedge clk);
        end
        check("burst_level", level, 4);
        check("burst_drop", drop_err, 0);
        check("burst_inflight_addr", bus.write_addr, 0);
        pulse_req(1'b1, 1'b0, 2'd3, 8'hEE);
        repeat (3) @(negedge clk);
        check("burst6_drop", drop_err, 1);
        check("burst6_level", level, 4);
        give_done(8'h00);
        for (int i = 1; i < 5; i++) begin
            wait_start($sformatf("burst_op%0d", i), 1'b0, 2'(i), 8'(8'h10 + i));
            give_done(8'h00);
        end
        check("burst_drain_busy", busy, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("burst_clr", drop_err, 0);

        // 4. collision: write issued, read dropped
        pulse_req(1'b1, 1'b1, 2'd1, 8'h3C);
        wait_start("coll", 1'b0, 2'd1, 8'h3C);
        check("coll_drop", drop_err, 1);
        give_done(8'h00);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.start_read || bus.start_write) starts++;
        end
        check("coll_no_read", starts, 0);
        check("coll_busy", busy, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("coll_clr", drop_err, 0);

        // 5. timeout, with a read queued behind the stalled write
        pulse_req(1'b1, 1'b0, 2'd3, 8'h77);
        wait_start("to_wr", 1'b0, 2'd3, 8'h77);
        k_to = 0;
        rsp_seen = 0;
        for (int k = 1; k <= 200 && k_to == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_addr = 2'd1;
                req_rd   = 1'b1;
            end
            if (k == 3) req_rd = 1'b0;
            if (rsp_valid) rsp_seen++;
            if (timeout_err) k_to = k;
        end
        check("to_latency", k_to, TO + 1);
        check("to_no_rsp", rsp_seen, 0);
        wait_start("to_next", 1'b1, 2'd1, 8'h00);
        give_done(8'h5A);
        check("to_next_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h5A});
        check("to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_clr", timeout_err, 0);

        // 6. reset mid-WAIT with two queued
        for (int i = 0; i < 3; i++) begin
            pulse_req(1'b1, 1'b0, 2'd3, 8'hC0 + 8'(i));
            repeat (3) @(negedge clk);
        end
        check("rstw_level_pre", level, 2);
        check("rstw_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstw_level", level, 0);
        check("rstw_busy", busy, 0);
        check("rstw_bus", {bus.start_write, bus.start_read, bus.write_addr, bus.wr_data}, 0);
        check("rstw_rsp", {rsp_valid, rsp_data}, 0);
        check("rstw_errs", {drop_err, timeout_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.start_read || bus.start_write) starts++;
        end
        check("rstw_no_start", starts, 0);
        check("rstw_level_post", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
